// File: rtl/fft_peak_finder.sv
// Finds the strongest positive-frequency bin of each AXI-stream FFT output frame
// and reports its index and magnitude-squared, flagging malformed frames.
module fft_peak_finder #(
  parameter int FFT_LENGTH = 1024,
  parameter int MIN_BIN    = 1,
  parameter int MAX_BIN    = 511
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [31:0]                   fft_data_in,
  input  logic                          fft_valid_in,
  input  logic                          fft_last_in,
  output logic                          fft_ready_out,
  output logic [$clog2(FFT_LENGTH)-1:0] peak_bin_out,
  output logic [31:0]                   peak_mag_out,
  output logic                          peak_valid_out,
  output logic                          frame_error_out
);

  localparam int BIN_W = $clog2(FFT_LENGTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  state_t state, state_nxt;

  logic             armed;
  logic             drain_cnt;
  logic             frame_err;
  logic [BIN_W-1:0] bin_cnt;
  logic             accept;
  logic             at_final;
  logic             frame_end;

  logic                    s1_valid;
  logic signed [15:0]      s1_re, s1_im;
  logic [BIN_W-1:0]        s1_bin;
  logic signed [30:0]      re_ext, im_ext;
  logic signed [30:0]      re_sq, im_sq;

  logic                    s2_valid;
  logic [30:0]             s2_rr, s2_ii;
  logic [BIN_W-1:0]        s2_bin;

  logic [31:0]             mag_sum;
  logic [31:0]             base_mag;
  logic [BIN_W-1:0]        base_bin;
  logic [31:0]             s2_bin_ext;
  logic                    in_range;
  logic                    take;
  logic [31:0]             run_mag;
  logic [BIN_W-1:0]        run_bin;

  // armed keeps tready low while reset is held and for the edge it is released on
  assign fft_ready_out = armed && (state == IDLE || state == ACCUM);
  assign accept        = fft_valid_in && fft_ready_out;
  assign at_final      = (bin_cnt == BIN_W'(FFT_LENGTH - 1));
  assign frame_end     = accept && (fft_last_in || at_final);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      armed     <= 1'b0;
      drain_cnt <= 1'b0;
      bin_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      armed     <= 1'b1;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (frame_end)
        bin_cnt <= '0;
      else if (accept)
        bin_cnt <= bin_cnt + 1'b1;
      // tlast and the final counter value must coincide for a well-formed frame
      if (frame_end)
        frame_err <= fft_last_in ^ at_final;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = frame_end ? DRAIN : ACCUM;
      ACCUM:   if (frame_end) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are widened to 31 bits; a square of a 16-bit value never exceeds 2^30
  assign re_ext = {{15{s1_re[15]}}, s1_re};
  assign im_ext = {{15{s1_im[15]}}, s1_im};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_bin   <= '0;
      s2_valid <= 1'b0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_bin   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_re  <= fft_data_in[31:16];
        s1_im  <= fft_data_in[15:0];
        s1_bin <= bin_cnt;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rr  <= re_sq;
        s2_ii  <= im_sq;
        s2_bin <= s1_bin;
      end
    end
  end

  // Bin 0 marks a new frame, so the running peak restarts from MIN_BIN with zero
  assign mag_sum    = {1'b0, s2_rr} + {1'b0, s2_ii};
  assign base_mag   = (s2_bin == '0) ? 32'd0 : run_mag;
  assign base_bin   = (s2_bin == '0) ? BIN_W'(MIN_BIN) : run_bin;
  assign s2_bin_ext = 32'(s2_bin);
  assign in_range   = (s2_bin_ext >= 32'(MIN_BIN)) && (s2_bin_ext <= 32'(MAX_BIN));
  assign take       = in_range && (mag_sum > base_mag);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_mag         <= '0;
      run_bin         <= '0;
      peak_valid_out  <= 1'b0;
      frame_error_out <= 1'b0;
      peak_bin_out    <= '0;
      peak_mag_out    <= '0;
    end else begin
      if (s2_valid) begin
        run_mag <= take ? mag_sum : base_mag;
        run_bin <= take ? s2_bin : base_bin;
      end
      peak_valid_out  <= (state == REPORT);
      frame_error_out <= (state == REPORT) && frame_err;
      if (state == REPORT) begin
        peak_bin_out <= run_bin;
        peak_mag_out <= run_mag;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Randomized bench for fft_peak_finder: frames are driven with random valid gaps
// and each report is compared against a plain arithmetic peak search.
module tb_fft_peak_finder;

  localparam int FFT = 1024;
  localparam int MINB = 1;
  localparam int MAXB = 511;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] fft_data_in;
  logic        fft_valid_in;
  logic        fft_last_in;
  logic        fft_ready_out;
  logic [9:0]  peak_bin_out;
  logic [31:0] peak_mag_out;
  logic        peak_valid_out;
  logic        frame_error_out;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  logic [31:0] frameData [FFT];

  fft_peak_finder #(.FFT_LENGTH(FFT), .MIN_BIN(MINB), .MAX_BIN(MAXB)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .fft_data_in(fft_data_in),
    .fft_valid_in(fft_valid_in),
    .fft_last_in(fft_last_in),
    .fft_ready_out(fft_ready_out),
    .peak_bin_out(peak_bin_out),
    .peak_mag_out(peak_mag_out),
    .peak_valid_out(peak_valid_out),
    .frame_error_out(frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (peak_valid_out === 1'b1) pulseCount++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int re, input int im);
    logic [15:0] r, i;
    r = 16'(re);
    i = 16'(im);
    return {r, i};
  endfunction

  task automatic clearFrame();
    for (int i = 0; i < FFT; i++) frameData[i] = 32'd0;
  endtask

  task automatic randomFrame(input int span);
    for (int i = 0; i < FFT; i++)
      frameData[i] = beat($urandom_range(2 * span) - span, $urandom_range(2 * span) - span);
  endtask

  // Reference: strongest in-range bin over the beats actually delivered, lower bin wins ties
  task automatic modelPeak(input int len, output int expBin, output longint expMag);
    logic signed [15:0] r, i;
    longint m;
    expBin = MINB;
    expMag = 0;
    for (int b = 0; b < len; b++) begin
      r = frameData[b][31:16];
      i = frameData[b][15:0];
      m = longint'(r) * longint'(r) + longint'(i) * longint'(i);
      if (b >= MINB && b <= MAXB && m > expMag) begin
        expBin = b;
        expMag = m;
      end
    end
  endtask

  task automatic applyStimulus(input string name, input int len, input bit withLast,
                               input int gapPct, input int abortAt);
    int idx = 0;
    int budget = 0;
    int startPulses;
    int expBin;
    longint expMag;
    bit acc;
    startPulses = pulseCount;
    while (idx < len && budget < 20000) begin
      @(negedge clk_in);
      if ($urandom_range(99) < gapPct) begin
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
      end else begin
        fft_valid_in = 1'b1;
        fft_data_in  = frameData[idx];
        fft_last_in  = withLast && (idx == len - 1);
      end
      acc = fft_valid_in && fft_ready_out;
      @(posedge clk_in);
      if (acc) idx++;
      budget++;
      if (abortAt > 0 && idx == abortAt) break;
    end
    if (budget >= 20000) checkOutput({name, "_accept_timeout"}, 64'(idx), 64'(len));
    @(negedge clk_in);
    fft_valid_in = 1'b0;
    fft_last_in  = 1'b0;
    if (abortAt > 0) begin
      rst_in = 1'b1;
      #1;
      checkOutput({name, "_rst_ready"}, 64'(fft_ready_out), 64'd0);
      checkOutput({name, "_rst_pvalid"}, 64'(peak_valid_out), 64'd0);
      checkOutput({name, "_rst_bin"}, 64'(peak_bin_out), 64'd0);
      checkOutput({name, "_rst_mag"}, 64'(peak_mag_out), 64'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      checkOutput({name, "_ready_after_rst"}, 64'(fft_ready_out), 64'd1);
      repeat (10) @(negedge clk_in);
      checkOutput({name, "_no_report"}, 64'(pulseCount - startPulses), 64'd0);
      return;
    end
    modelPeak(len, expBin, expMag);
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("%s_ready_low%0d", name, k), 64'(fft_ready_out), 64'd0);
      checkOutput($sformatf("%s_pvalid_early%0d", name, k), 64'(peak_valid_out), 64'd0);
      if (k < 3) @(negedge clk_in);
    end
    @(negedge clk_in);
    checkOutput({name, "_pvalid"}, 64'(peak_valid_out), 64'd1);
    checkOutput({name, "_ready_back"}, 64'(fft_ready_out), 64'd1);
    checkOutput({name, "_bin"}, 64'(peak_bin_out), 64'(expBin));
    checkOutput({name, "_mag"}, 64'(peak_mag_out), 64'(expMag));
    checkOutput({name, "_err"}, 64'(frame_error_out), 64'((withLast && len == FFT) ? 0 : 1));
    @(negedge clk_in);
    checkOutput({name, "_pulse_once"}, 64'(peak_valid_out), 64'd0);
    checkOutput({name, "_err_once"}, 64'(frame_error_out), 64'd0);
    checkOutput({name, "_bin_hold"}, 64'(peak_bin_out), 64'(expBin));
    checkOutput({name, "_pulses"}, 64'(pulseCount - startPulses), 64'd1);
  endtask

  initial begin
    rst_in       = 1'b1;
    fft_valid_in = 1'b0;
    fft_last_in  = 1'b0;
    fft_data_in  = 32'd0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("reset_ready", 64'(fft_ready_out), 64'd0);
    checkOutput("reset_pvalid", 64'(peak_valid_out), 64'd0);
    checkOutput("reset_err", 64'(frame_error_out), 64'd0);
    checkOutput("reset_bin", 64'(peak_bin_out), 64'd0);
    checkOutput("reset_mag", 64'(peak_mag_out), 64'd0);
    rst_in = 1'b0;
    #1;
    checkOutput("ready_before_edge", 64'(fft_ready_out), 64'd0);
    @(negedge clk_in);
    checkOutput("ready_after_edge", 64'(fft_ready_out), 64'd1);

    clearFrame();
    frameData[100] = beat(300, 400);
    applyStimulus("single_peak", FFT, 1'b1, 0, 0);
    applyStimulus("single_peak_gaps", FFT, 1'b1, 50, 0);

    clearFrame();
    frameData[50] = beat(1000, 0);
    frameData[60] = beat(1000, 0);
    applyStimulus("tie_lower", FFT, 1'b1, 20, 0);

    clearFrame();
    frameData[0]   = beat(32767, 0);
    frameData[700] = beat(-32768, -32768);
    frameData[5]   = beat(0, 10);
    applyStimulus("range_limits", FFT, 1'b1, 10, 0);

    clearFrame();
    applyStimulus("all_zero", FFT, 1'b1, 0, 0);

    randomFrame(30000);
    applyStimulus("short_frame", 500, 1'b1, 30, 0);
    randomFrame(30000);
    applyStimulus("after_short", FFT, 1'b1, 30, 0);

    randomFrame(32768);
    applyStimulus("missing_last", FFT, 1'b0, 40, 0);

    randomFrame(1000);
    applyStimulus("one_beat", 1, 1'b1, 0, 0);

    randomFrame(20000);
    frameData[250] = beat(-32768, -32768);
    applyStimulus("reset_mid", FFT, 1'b1, 25, 300);
    randomFrame(20000);
    applyStimulus("after_reset", FFT, 1'b1, 30, 0);

    randomFrame(2);
    applyStimulus("many_ties", FFT, 1'b1, 50, 0);
    randomFrame(32768);
    applyStimulus("random_full", FFT, 1'b1, 50, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
